// File: rtl/nes_pkg.sv
// nes_pkg: button bit positions and poll FSM state encoding shared with the game-state logic
package nes_pkg;
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for the asynchronous controller data line, resets to released (1)
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic m;
   // shift the raw input through two flops
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, m} <= 2'b11;
      else        {q, m} <= {m, d};
endmodule

// File: rtl/nes_controller.sv
// nes_controller: once-per-frame NES gamepad poll producing stable button state and press edges
module nes_controller
   import nes_pkg::*;
#(
   parameter int HALF_CYC = 151
) (
   input  logic       pixel_Clk,
   input  logic       reset_n,
   input  logic       VSyncStart,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic [7:0] buttons_rise,
   output logic       poll_valid,
   output logic       busy
);
   localparam int CW = $clog2(HALF_CYC);
   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          half;
   logic [2:0]    k;
   logic [7:0]    shift;
   logic          data_s;
   logic          end_half, end_phase;

   sync_2ff u_sync (
      .clk   (pixel_Clk),
      .rst_n (reset_n),
      .d     (nes_data),
      .q     (data_s)
   );

   assign end_half  = cnt == CW'(HALF_CYC - 1);
   assign end_phase = end_half && half;

   // state register
   always_ff @(posedge pixel_Clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;

   // next-state: one latch phase, eight bit phases, one publish cycle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = VSyncStart ? LATCH : IDLE;
         LATCH: state_nx = end_phase ? SHIFT : LATCH;
         SHIFT: state_nx = (end_phase && k == 3'd7) ? DONE : SHIFT;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // protocol outputs; bit 0 is valid right after latch so its phase keeps the clock high
   always_comb begin
      nes_latch = state == LATCH;
      nes_clk   = !(state == SHIFT && k != 3'd0 && !half);
      busy      = state != IDLE;
   end

   // half-period timing, bit index and sampling of each bit at the end of its phase
   always_ff @(posedge pixel_Clk or negedge reset_n)
      if (!reset_n) begin
         cnt   <= '0;
         half  <= 1'b0;
         k     <= 3'd0;
         shift <= 8'd0;
      end else if (state == LATCH || state == SHIFT) begin
         cnt  <= end_half ? '0 : cnt + 1'b1;
         half <= end_half ? ~half : half;
         if (state == SHIFT && end_phase) begin
            shift[k] <= data_s;
            k        <= (k == 3'd7) ? k : k + 3'd1;
         end
      end else begin
         cnt  <= '0;
         half <= 1'b0;
         k    <= 3'd0;
      end

   // publish inverted (active-high) buttons and new presses once per poll
   always_ff @(posedge pixel_Clk or negedge reset_n)
      if (!reset_n) begin
         buttons      <= 8'd0;
         buttons_rise <= 8'd0;
         poll_valid   <= 1'b0;
      end else begin
         poll_valid <= state == DONE;
         if (state == DONE) begin
            buttons      <= ~shift;
            buttons_rise <= ~shift & ~buttons;
         end
      end
endmodule

// File: tb/tb_nes_controller.sv
// tb_nes_controller: directed and random polls against a behavioural gamepad and expectation model
module tb_nes_controller;
   localparam int H = 4;
   logic       clk = 0, reset_n = 0, vsync = 0, nes_data;
   logic       nes_latch, nes_clk, poll_valid, busy;
   logic [7:0] buttons, buttons_rise;
   int         errors = 0, checks = 0;
   logic [7:0] pad = 8'd0;
   logic [7:0] exp_btn = 8'd0;
   int         idx = 0;
   logic       prev_nclk = 1;

   nes_controller #(.HALF_CYC(H)) dut (
      .pixel_Clk    (clk),
      .reset_n      (reset_n),
      .VSyncStart   (vsync),
      .nes_data     (nes_data),
      .nes_latch    (nes_latch),
      .nes_clk      (nes_clk),
      .buttons      (buttons),
      .buttons_rise (buttons_rise),
      .poll_valid   (poll_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // gamepad: latch reloads, each rising shift clock presents the next button, low = pressed
   always @(negedge clk) begin
      if (nes_latch) idx = 0;
      else if (nes_clk && !prev_nclk) idx = idx + 1;
      prev_nclk = nes_clk;
   end
   assign nes_data = (idx < 8) ? ~pad[idx[2:0]] : 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0 normal, 1 extra pulses while busy, 2 pulse during the publish cycle, 3 reset at cycle 30
   task automatic poll(input logic [7:0] p, input int mode);
      int n, lat, lows, pulses, pv;
      logic pc;
      pad = p;
      @(negedge clk) vsync = 1;
      @(negedge clk) vsync = 0;
      check("busy_start", busy, 1);
      check("latch_start", nes_latch, 1);
      n = 0; lat = 0; lows = 0; pulses = 0; pc = 1;
      while (!poll_valid && n < 200) begin
         lat += nes_latch;
         lows += !nes_clk;
         if (pc && !nes_clk) pulses++;
         pc = nes_clk;
         if (mode == 3 && n == 30) begin
            reset_n = 0;
            #1;
            check("rst_latch", nes_latch, 0);
            check("rst_clk", nes_clk, 1);
            check("rst_buttons", buttons, 0);
            check("rst_busy", busy, 0);
            exp_btn = 8'd0;
            @(negedge clk) reset_n = 1;
            repeat (3) @(negedge clk);
            check("rst_idle", busy, 0);
            return;
         end
         if (n == 72) check("busy_last", busy, 1);
         vsync = (mode == 1 && (n == 10 || n == 40)) || (mode == 2 && n == 72);
         @(negedge clk);
         vsync = 0;
         n++;
      end
      check("poll_cycles", n, 18 * H + 1);
      check("busy_end", busy, 0);
      check("latch_cycles", lat, 2 * H);
      check("clk_pulses", pulses, 7);
      check("clk_low_cycles", lows, 7 * H);
      check("buttons", buttons, p);
      check("buttons_rise", buttons_rise, p & ~exp_btn);
      exp_btn = p;
      pv = 0;
      repeat (20) begin
         @(negedge clk);
         pv += poll_valid;
         if (busy) pv += 100;
      end
      check("quiet_after", pv, 0);
      check("hold_buttons", buttons, p);
   endtask

   initial begin
      #1;
      check("r_latch", nes_latch, 0);
      check("r_clk", nes_clk, 1);
      check("r_buttons", buttons, 0);
      check("r_rise", buttons_rise, 0);
      check("r_valid", poll_valid, 0);
      check("r_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1;
      repeat (2) @(negedge clk);
      poll(8'b0000_1001, 0);
      poll(8'b0000_1001, 0);
      check("rise_repeat", buttons_rise, 0);
      poll(8'b0001_1001, 0);
      check("rise_up", buttons_rise, 8'b0001_0000);
      poll(8'b1010_0101, 1);
      poll(8'b0101_1010, 2);
      poll(8'b1111_1111, 3);
      poll(8'b0110_0011, 0);
      poll(8'd0, 0);
      poll(8'd0, 0);
      check("disc_rise", buttons_rise, 0);
      repeat (6) poll(8'($urandom), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
